// File: rtl/pac_pkg.sv
// Shared definitions for the Pac-Man game blocks: life/death FSM encoding and frame-count
// defaults used by the life controller, movement and VGA logic.
package pac_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReady = 3'd1,
      StPlay  = 3'd2,
      StDying = 3'd3,
      StOver  = 3'd4
   } pac_state_e;

   localparam int unsigned LivesInitDef     = 3;
   localparam int unsigned LivesWDef        = 3;
   localparam int unsigned CrashFramesDef   = 2;
   localparam int unsigned DeathFramesDef   = 90;
   localparam int unsigned RespawnFramesDef = 60;
   localparam int unsigned AnimW            = 7;

   // Timer load value so that expiry lands on the frames-th tick after loading.
   function automatic logic [AnimW-1:0] frames_to_load(input int unsigned frames);
      return AnimW'(frames - 1);
   endfunction

endpackage

// File: rtl/pac_tick_timer.sv
// Loadable down-counter that only advances on the frame tick; expire_o flags the tick that
// arrives while the count is already zero.
module pac_tick_timer #(
   parameter int unsigned W = 7
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         tick_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] count_o,
   output logic         expire_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign expire_o = tick_i & (count_q == '0);

endmodule

// File: rtl/pac_life_ctrl.sv
// Pac-Man life/death controller: crash filtering, death animation, respawn and game over.
// Define PAC_POWER_PELLET_EN to add frightened_i / ghost_eaten_o (crash eats the ghost instead).
module pac_life_ctrl
   import pac_pkg::*;
#(
   parameter int unsigned LIVES_INIT     = LivesInitDef,
   parameter int unsigned LW             = LivesWDef,
   parameter int unsigned CRASH_FRAMES   = CrashFramesDef,
   parameter int unsigned DEATH_FRAMES   = DeathFramesDef,
   parameter int unsigned RESPAWN_FRAMES = RespawnFramesDef
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick_i,
   input  logic             crash_i,
   input  logic             start_i,
`ifdef PAC_POWER_PELLET_EN
   input  logic             frightened_i,
   output logic             ghost_eaten_o,
`endif
   output logic             freeze_o,
   output logic             respawn_o,
   output logic             dying_o,
   output logic [AnimW-1:0] anim_frame_o,
   output logic [LW-1:0]    lives_o,
   output logic             game_over_o
);

   localparam int unsigned CntW = $clog2(CRASH_FRAMES + 1);

   pac_state_e       state_q, state_d;
   logic [LW-1:0]    lives_q, lives_d;
   logic [CntW-1:0]  crash_cnt_q, crash_cnt_d;
   logic             respawn_q, respawn_d;
   logic             start_q;
   logic             start_rise;
   logic             crash_qual;
   logic             kill;
   logic             count_block;
   logic             timer_load;
   logic [AnimW-1:0] timer_val;
   logic [AnimW-1:0] timer_count;
   logic             timer_expire;

   assign start_rise = start_i & ~start_q;

`ifdef PAC_POWER_PELLET_EN
   logic hold_q, hold_d;
   logic eaten_q, eaten_d;

   assign count_block   = hold_q;
   assign kill          = crash_qual & ~frightened_i;
   assign ghost_eaten_o = eaten_q;

   // After an eat, counting stays suspended until a tick sees crash low again.
   always_comb begin
      hold_d  = hold_q;
      eaten_d = 1'b0;
      if (state_q != StPlay) begin
         hold_d = 1'b0;
      end else if (tick_i && !crash_i) begin
         hold_d = 1'b0;
      end else if (crash_qual && frightened_i) begin
         hold_d  = 1'b1;
         eaten_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q  <= 1'b0;
         eaten_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         eaten_q <= eaten_d;
      end
   end
`else
   assign count_block = 1'b0;
   assign kill        = crash_qual;
`endif

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      crash_cnt_d = crash_cnt_q;
      respawn_d   = 1'b0;
      crash_qual  = 1'b0;
      timer_load  = 1'b0;
      timer_val   = frames_to_load(RESPAWN_FRAMES);

      case (state_q)
         StIdle, StOver: begin
            if (start_rise) begin
               state_d    = StReady;
               lives_d    = LW'(LIVES_INIT);
               respawn_d  = 1'b1;
               timer_load = 1'b1;
            end
         end
         StReady: begin
            if (timer_expire) begin
               state_d     = StPlay;
               crash_cnt_d = '0;
            end
         end
         StPlay: begin
            if (tick_i) begin
               if (!crash_i) begin
                  crash_cnt_d = '0;
               end else if (!count_block) begin
                  if (crash_cnt_q == CntW'(CRASH_FRAMES - 1)) begin
                     crash_qual  = 1'b1;
                     crash_cnt_d = '0;
                  end else begin
                     crash_cnt_d = crash_cnt_q + 1'b1;
                  end
               end
            end
            if (kill) begin
               state_d    = StDying;
               lives_d    = (lives_q == '0) ? '0 : lives_q - 1'b1;
               timer_load = 1'b1;
               timer_val  = frames_to_load(DEATH_FRAMES);
            end
         end
         StDying: begin
            if (timer_expire) begin
               if (lives_q == '0) begin
                  state_d = StOver;
               end else begin
                  state_d    = StReady;
                  respawn_d  = 1'b1;
                  timer_load = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         lives_q     <= LW'(LIVES_INIT);
         crash_cnt_q <= '0;
         respawn_q   <= 1'b0;
         start_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         crash_cnt_q <= crash_cnt_d;
         respawn_q   <= respawn_d;
         start_q     <= start_i;
      end
   end

   pac_tick_timer #(
      .W (AnimW)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick_i     (tick_i),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .count_o    (timer_count),
      .expire_o   (timer_expire)
   );

   assign freeze_o     = (state_q != StPlay);
   assign respawn_o    = respawn_q;
   assign dying_o      = (state_q == StDying);
   assign anim_frame_o = dying_o ? (AnimW'(DEATH_FRAMES - 1) - timer_count) : '0;
   assign lives_o      = lives_q;
   assign game_over_o  = (state_q == StOver);

endmodule

// File: tb/tb_pac_life_ctrl.sv
// Directed bench for pac_life_ctrl with default parameters.
module tb_pac_life_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       tick_i = 1'b0;
   logic       crash_i = 1'b0;
   logic       start_i = 1'b0;
   logic       freeze_o, respawn_o, dying_o, game_over_o;
   logic [6:0] anim_frame_o;
   logic [2:0] lives_o;
`ifdef PAC_POWER_PELLET_EN
   logic       frightened_i = 1'b0;
   logic       ghost_eaten_o;
   int         eaten_cnt = 0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int respawn_cnt = 0;
   int base;

   pac_life_ctrl dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .tick_i       (tick_i),
      .crash_i      (crash_i),
      .start_i      (start_i),
`ifdef PAC_POWER_PELLET_EN
      .frightened_i (frightened_i),
      .ghost_eaten_o(ghost_eaten_o),
`endif
      .freeze_o     (freeze_o),
      .respawn_o    (respawn_o),
      .dying_o      (dying_o),
      .anim_frame_o (anim_frame_o),
      .lives_o      (lives_o),
      .game_over_o  (game_over_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (respawn_o === 1'b1) respawn_cnt++;
`ifdef PAC_POWER_PELLET_EN
      if (ghost_eaten_o === 1'b1) eaten_cnt++;
`endif
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_i = 1'b1;
         step();
         tick_i = 1'b0;
         step();
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; start_i = 1'b0; crash_i = 1'b0; tick_i = 1'b0;
      step(); step();
      n_checks++; if (freeze_o !== 1'b1) begin n_errors++; $display("FAIL reset_freeze: got %b want 1", freeze_o); end
      n_checks++; if (respawn_o !== 1'b0) begin n_errors++; $display("FAIL reset_respawn: got %b want 0", respawn_o); end
      n_checks++; if (dying_o !== 1'b0) begin n_errors++; $display("FAIL reset_dying: got %b want 0", dying_o); end
      n_checks++; if (anim_frame_o !== 7'd0) begin n_errors++; $display("FAIL reset_anim: got %0d want 0", anim_frame_o); end
      n_checks++; if (lives_o !== 3'd3) begin n_errors++; $display("FAIL reset_lives: got %0d want 3", lives_o); end
      n_checks++; if (game_over_o !== 1'b0) begin n_errors++; $display("FAIL reset_game_over: got %b want 0", game_over_o); end
      rst_ni = 1'b1;
      step(); step();
   endtask

   task automatic test_start();
      start_i = 1'b1;
      step();
      n_checks++; if (respawn_o !== 1'b1) begin n_errors++; $display("FAIL start_respawn: got %b want 1", respawn_o); end
      start_i = 1'b0;
      step();
      n_checks++; if (respawn_o !== 1'b0) begin n_errors++; $display("FAIL start_respawn_width: got %b want 0", respawn_o); end
      ticks(59);
      n_checks++; if (freeze_o !== 1'b1) begin n_errors++; $display("FAIL ready_59: freeze got %b want 1", freeze_o); end
      ticks(1);
      n_checks++; if (freeze_o !== 1'b0) begin n_errors++; $display("FAIL ready_60: freeze got %b want 0", freeze_o); end
   endtask

   task automatic test_short_crash();
      crash_i = 1'b1; ticks(1);
      crash_i = 1'b0; ticks(1);
      crash_i = 1'b1; ticks(1);
      crash_i = 1'b0; ticks(2);
      n_checks++; if (freeze_o !== 1'b0 || dying_o !== 1'b0) begin n_errors++; $display("FAIL short_crash: freeze %b dying %b want 0 0", freeze_o, dying_o); end
      n_checks++; if (lives_o !== 3'd3) begin n_errors++; $display("FAIL short_crash_lives: got %0d want 3", lives_o); end
      base = respawn_cnt;
      start_i = 1'b1; step(); step();
      start_i = 1'b0; step();
      n_checks++; if (freeze_o !== 1'b0 || respawn_cnt != base) begin n_errors++; $display("FAIL start_in_play: freeze %b respawns %0d want 0 0", freeze_o, respawn_cnt - base); end
   endtask

`ifdef PAC_POWER_PELLET_EN
   task automatic test_pellet();
      base = eaten_cnt;
      frightened_i = 1'b1; crash_i = 1'b1;
      ticks(1);
      tick_i = 1'b1; step(); tick_i = 1'b0;
      n_checks++; if (ghost_eaten_o !== 1'b1) begin n_errors++; $display("FAIL pellet_eat: got %b want 1", ghost_eaten_o); end
      step();
      n_checks++; if (ghost_eaten_o !== 1'b0) begin n_errors++; $display("FAIL pellet_width: got %b want 0", ghost_eaten_o); end
      ticks(3);
      n_checks++; if (eaten_cnt - base != 1) begin n_errors++; $display("FAIL pellet_count: got %0d want 1", eaten_cnt - base); end
      n_checks++; if (lives_o !== 3'd3 || freeze_o !== 1'b0) begin n_errors++; $display("FAIL pellet_state: lives %0d freeze %b want 3 0", lives_o, freeze_o); end
      frightened_i = 1'b0; crash_i = 1'b0;
      ticks(1);
   endtask
`endif

   // Crash is held high from the first death through READY, DYING and the next PLAY.
   task automatic test_death();
      crash_i = 1'b1;
      ticks(1);
      n_checks++; if (dying_o !== 1'b0) begin n_errors++; $display("FAIL death_tick1: dying got %b want 0", dying_o); end
      ticks(1);
      n_checks++; if (dying_o !== 1'b1 || freeze_o !== 1'b1) begin n_errors++; $display("FAIL death_tick2: dying %b freeze %b want 1 1", dying_o, freeze_o); end
      n_checks++; if (lives_o !== 3'd2) begin n_errors++; $display("FAIL death_lives: got %0d want 2", lives_o); end
      n_checks++; if (anim_frame_o !== 7'd0) begin n_errors++; $display("FAIL death_anim0: got %0d want 0", anim_frame_o); end
      ticks(40);
      n_checks++; if (anim_frame_o !== 7'd40) begin n_errors++; $display("FAIL death_anim40: got %0d want 40", anim_frame_o); end
      ticks(49);
      n_checks++; if (anim_frame_o !== 7'd89 || dying_o !== 1'b1) begin n_errors++; $display("FAIL death_anim89: anim %0d dying %b want 89 1", anim_frame_o, dying_o); end
      base = respawn_cnt;
      ticks(1);
      n_checks++; if (respawn_cnt - base != 1) begin n_errors++; $display("FAIL death_respawn: pulses %0d want 1", respawn_cnt - base); end
      n_checks++; if (dying_o !== 1'b0 || freeze_o !== 1'b1 || anim_frame_o !== 7'd0) begin n_errors++; $display("FAIL death_ready: dying %b freeze %b anim %0d want 0 1 0", dying_o, freeze_o, anim_frame_o); end
      ticks(60);
      n_checks++; if (freeze_o !== 1'b0 || lives_o !== 3'd2) begin n_errors++; $display("FAIL replay: freeze %b lives %0d want 0 2", freeze_o, lives_o); end
      ticks(1);
      n_checks++; if (dying_o !== 1'b0) begin n_errors++; $display("FAIL fresh_tick1: dying got %b want 0", dying_o); end
      ticks(1);
      n_checks++; if (dying_o !== 1'b1 || lives_o !== 3'd1) begin n_errors++; $display("FAIL death2: dying %b lives %0d want 1 1", dying_o, lives_o); end
   endtask

   task automatic test_game_over();
      ticks(90);
      ticks(60);
      ticks(2);
      n_checks++; if (dying_o !== 1'b1 || lives_o !== 3'd0) begin n_errors++; $display("FAIL death3: dying %b lives %0d want 1 0", dying_o, lives_o); end
      base = respawn_cnt;
      ticks(90);
      n_checks++; if (game_over_o !== 1'b1 || lives_o !== 3'd0 || freeze_o !== 1'b1) begin n_errors++; $display("FAIL over: go %b lives %0d freeze %b want 1 0 1", game_over_o, lives_o, freeze_o); end
      n_checks++; if (respawn_cnt != base) begin n_errors++; $display("FAIL over_no_respawn: pulses %0d want 0", respawn_cnt - base); end
      ticks(3);
      n_checks++; if (lives_o !== 3'd0 || game_over_o !== 1'b1) begin n_errors++; $display("FAIL over_hold: lives %0d go %b want 0 1", lives_o, game_over_o); end
      crash_i = 1'b0;
      start_i = 1'b1;
      step();
      n_checks++; if (respawn_o !== 1'b1 || lives_o !== 3'd3 || game_over_o !== 1'b0 || freeze_o !== 1'b1) begin n_errors++; $display("FAIL restart: resp %b lives %0d go %b freeze %b want 1 3 0 1", respawn_o, lives_o, game_over_o, freeze_o); end
      start_i = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_dying();
      ticks(60);
      crash_i = 1'b1;
      ticks(2);
      crash_i = 1'b0;
      ticks(40);
      n_checks++; if (anim_frame_o !== 7'd40 || dying_o !== 1'b1) begin n_errors++; $display("FAIL pre_rst_anim: anim %0d dying %b want 40 1", anim_frame_o, dying_o); end
      start_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1;
      n_checks++; if (dying_o !== 1'b0 || anim_frame_o !== 7'd0 || lives_o !== 3'd3 || freeze_o !== 1'b1) begin n_errors++; $display("FAIL async_rst: dying %b anim %0d lives %0d freeze %b want 0 0 3 1", dying_o, anim_frame_o, lives_o, freeze_o); end
      step();
      n_checks++; if (respawn_o !== 1'b0 || game_over_o !== 1'b0) begin n_errors++; $display("FAIL rst_hold: resp %b go %b want 0 0", respawn_o, game_over_o); end
      base = respawn_cnt;
      rst_ni = 1'b1;
      step(); step();
      ticks(62);
      n_checks++; if (respawn_cnt != base || freeze_o !== 1'b1) begin n_errors++; $display("FAIL held_start: pulses %0d freeze %b want 0 1", respawn_cnt - base, freeze_o); end
      start_i = 1'b0; step();
      start_i = 1'b1; step();
      n_checks++; if (respawn_o !== 1'b1) begin n_errors++; $display("FAIL fresh_start: got %b want 1", respawn_o); end
      start_i = 1'b0; step();
   endtask

   initial begin
      test_reset();
      test_start();
      test_short_crash();
`ifdef PAC_POWER_PELLET_EN
      test_pellet();
`endif
      test_death();
      test_game_over();
      test_reset_mid_dying();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
